// File: rtl/sea_round_ctrl.sv
// SEA block-cipher round sequencer: loads a block, drives NR rounds through an
// external datapath, swaps halves on the last round. Optional abort via SEA_ABORT_EN.
module sea_round_ctrl #(
  parameter int unsigned NR = 52,
  parameter int unsigned W  = 48
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SEA_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] l_in,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] kl_in,
  input  logic [W-1:0] kr_in,
  output logic [W-1:0] rnd_l,
  output logic [W-1:0] rnd_r,
  output logic [W-1:0] rnd_kl,
  output logic [W-1:0] rnd_kr,
  output logic         rnd_dir,
  output logic         rnd_en,
  output logic [7:0]   rnd_idx,
  output logic         ks_swap,
  input  logic [W-1:0] nxt_l,
  input  logic [W-1:0] nxt_r,
  input  logic [W-1:0] nxt_kl,
  input  logic [W-1:0] nxt_kr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] l_out,
  output logic [W-1:0] r_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NR - 1);
  localparam logic [7:0] SWAP_IDX = 8'(NR / 2 - 1);

  state_t       state_q, state_d;
  logic [W-1:0] l_q, l_d, r_q, r_d, kl_q, kl_d, kr_q, kr_d;
  logic [W-1:0] lout_q, lout_d, rout_q, rout_d;
  logic [7:0]   idx_q, idx_d;
  logic         dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    kl_d    = kl_q;
    kr_d    = kr_q;
    lout_d  = lout_q;
    rout_d  = rout_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = l_in;
          r_d     = r_in;
          kl_d    = kl_in;
          kr_d    = kr_in;
          dir_d   = mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d  = nxt_l;
        r_d  = nxt_r;
        kl_d = nxt_kl;
        kr_d = nxt_kr;
        // index saturates at the last round; the final result is stored half-swapped
        if (idx_q == LAST_IDX) begin
          lout_d  = nxt_r;
          rout_d  = nxt_l;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SEA_ABORT_EN
    // abort overrides everything above, including the output handshake
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      l_d     = '0;
      r_d     = '0;
      kl_d    = '0;
      kr_d    = '0;
      lout_d  = '0;
      rout_d  = '0;
      idx_d   = '0;
      dir_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      kl_q    <= '0;
      kr_q    <= '0;
      lout_q  <= '0;
      rout_q  <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      kl_q    <= kl_d;
      kr_q    <= kr_d;
      lout_q  <= lout_d;
      rout_q  <= rout_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rnd_en    = (state_q == RUN);
  assign ks_swap   = (state_q == RUN) && (idx_q == SWAP_IDX);
  assign out_valid = (state_q == DONE);
  assign rnd_l     = l_q;
  assign rnd_r     = r_q;
  assign rnd_kl    = kl_q;
  assign rnd_kr    = kr_q;
  assign rnd_dir   = dir_q;
  assign rnd_idx   = idx_q;
  assign l_out     = lout_q;
  assign r_out     = rout_q;

endmodule

// File: tb/tb_sea_round_ctrl.sv
// Self-checking bench for sea_round_ctrl: block-level reference model plus directed
// scenarios; the abort scenario is built only when SEA_ABORT_EN is defined.
module tb_sea_round_ctrl;
  localparam int unsigned NR  = 52;
  localparam int unsigned W   = 48;
  localparam int          NRI = NR;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, mode, out_ready;
  logic [W-1:0] l_in, r_in, kl_in, kr_in;
  logic [W-1:0] nxt_l, nxt_r, nxt_kl, nxt_kr;
  logic         in_ready, rnd_dir, rnd_en, ks_swap, out_valid, busy;
  logic [W-1:0] rnd_l, rnd_r, rnd_kl, rnd_kr, l_out, r_out;
  logic [7:0]   rnd_idx;
`ifdef SEA_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  sea_round_ctrl #(.NR(NR), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEA_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .l_in(l_in), .r_in(r_in), .kl_in(kl_in), .kr_in(kr_in),
    .rnd_l(rnd_l), .rnd_r(rnd_r), .rnd_kl(rnd_kl), .rnd_kr(rnd_kr),
    .rnd_dir(rnd_dir), .rnd_en(rnd_en), .rnd_idx(rnd_idx), .ks_swap(ks_swap),
    .nxt_l(nxt_l), .nxt_r(nxt_r), .nxt_kl(nxt_kl), .nxt_kr(nxt_kr),
    .out_valid(out_valid), .out_ready(out_ready),
    .l_out(l_out), .r_out(r_out), .busy(busy)
  );

  // External round datapath: loopback or a toy Feistel round with key-half swap.
  logic loopback = 1'b0;
  always_comb begin
    nxt_l = rnd_l; nxt_r = rnd_r; nxt_kl = rnd_kl; nxt_kr = rnd_kr;
    if (!loopback) begin
      nxt_l  = rnd_r;
      nxt_r  = rnd_l ^ (rnd_r + rnd_kl + W'(rnd_idx) + (rnd_dir ? W'(5) : W'(3)));
      nxt_kl = ks_swap ? rnd_kr : rnd_kl + W'(1);
      nxt_kr = ks_swap ? rnd_kl : rnd_kr ^ W'(1);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-block result {l_out, r_out} for the datapath above.
  function automatic logic [2*W-1:0] sea_model(input logic [W-1:0] l0, r0, kl0, kr0,
                                               input logic dir, input logic lb);
    logic [W-1:0] l, r, kl, kr, t;
    l = l0; r = r0; kl = kl0; kr = kr0;
    if (!lb) begin
      for (int unsigned i = 0; i < NR; i++) begin
        t = l ^ (r + kl + W'(i) + (dir ? W'(5) : W'(3)));
        l = r;
        r = t;
        if (i == NR / 2 - 1) begin t = kl; kl = kr; kr = t; end
        else begin kl = kl + W'(1); kr = kr ^ W'(1); end
      end
    end
    return {r, l};
  endfunction

  // Block-level model: -1 idle, 0..NR-1 round in progress, NR result pending.
  int               m_cnt = -1;
  logic [W-1:0]     m_l, m_r, m_kl, m_kr;
  logic             m_dir;
  logic [2*W-1:0]   m_res;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) m_cnt = -1;
`ifdef SEA_ABORT_EN
    else if (abort && m_cnt >= 0) m_cnt = -1;
`endif
    else if (m_cnt < 0) begin
      if (in_valid) begin
        m_l = l_in; m_r = r_in; m_kl = kl_in; m_kr = kr_in; m_dir = mode;
        m_res = sea_model(l_in, r_in, kl_in, kr_in, mode, loopback);
        m_cnt = 0;
      end
    end
    else if (m_cnt < NRI) m_cnt++;
    else if (out_ready) m_cnt = -1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_cnt < 0);
      check("busy", busy, m_cnt >= 0);
      check("rnd_en", rnd_en, m_cnt >= 0 && m_cnt < NRI);
      check("ks_swap", ks_swap, m_cnt == NRI / 2 - 1);
      check("out_valid", out_valid, m_cnt == NRI);
      if (m_cnt >= 0 && m_cnt < NRI) begin
        check("rnd_idx", rnd_idx, m_cnt);
        check("rnd_dir", rnd_dir, m_dir);
      end
      if (m_cnt == 0)
        check("rnd_load", {rnd_l, rnd_r, rnd_kl, rnd_kr}, {m_l, m_r, m_kl, m_kr});
      if (m_cnt == NRI) check("result", {l_out, r_out}, m_res);
    end
  end

  task automatic start_block(input logic [W-1:0] l, r, kl, kr, input logic md);
    @(negedge clk);
    l_in = l; r_in = r; kl_in = kl; kr_in = kr; mode = md; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [7:0] v);
    int n = 0;
    while (!(rnd_en && rnd_idx == v) && n < 300) begin @(negedge clk); n++; end
    check("wait_idx_timeout", n < 300, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check("wait_done_timeout", n < 300, 1);
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  localparam logic [W-1:0] A  = 48'h0123_4567_89AB, B  = 48'hFEDC_BA98_7654;
  localparam logic [W-1:0] KA = 48'h1111_2222_3333, KB = 48'h4444_5555_6666;
  localparam logic [W-1:0] C  = 48'hA5A5_5A5A_0F0F, D  = 48'h0000_FFFF_1234;

  initial begin
    int k, sw, swidx;
    logic [2*W-1:0] expa;
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
    l_in = '0; r_in = '0; kl_in = '0; kr_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {busy, rnd_en, ks_swap, out_valid, rnd_dir}, 0);
    check("rst_idx", rnd_idx, 0);
    check("rst_rnd_lr", {rnd_l, rnd_r}, 0);
    check("rst_rnd_k", {rnd_kl, rnd_kr}, 0);
    check("rst_out", {l_out, r_out}, 0);
    check("model_pin_loopback", sea_model(A, B, KA, KB, 1'b0, 1'b1), {B, A});
    chk_en = 1'b1;

    // loopback block: latency, single ks_swap strobe, halves swapped
    loopback = 1'b1;
    start_block(A, B, KA, KB, 1'b0);
    check("in_ready_fall", in_ready, 0);
    k = 0; sw = 0; swidx = 0;
    while (!out_valid && k < 300) begin
      if (ks_swap) begin sw++; swidx = rnd_idx; end
      @(negedge clk); k++;
    end
    check("latency", k, NR);
    check("swap_count", sw, 1);
    check("swap_idx", swidx, 25);
    check("lb_l_out", l_out, B);
    check("lb_r_out", r_out, A);

    // hold result under backpressure, then handshake with in_valid already high
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", {l_out, r_out}, {B, A});
    end
    l_in = C; r_in = D; kl_in = KA; kr_in = KB; mode = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("no_accept_on_handshake", {in_ready, busy, out_valid}, 3'b100);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_idle", busy, 1);
    wait_done();
    check("lb2_out", {l_out, r_out}, {D, C});
    drain();

    // toy datapath, encrypt then decrypt with out_ready held high
    loopback = 1'b0;
    start_block(A, B, KA, KB, 1'b0);
    wait_done();
    check("enc_result", {l_out, r_out}, sea_model(A, B, KA, KB, 1'b0, 1'b0));
    drain();
    out_ready = 1'b1;
    start_block(C, D, KB, KA, 1'b1);
    wait_done();
    @(negedge clk);
    check("dec_released", in_ready, 1);
    out_ready = 1'b0;

    // request while busy is ignored
    expa = sea_model(D, A, KA, KA, 1'b0, 1'b0);
    start_block(D, A, KA, KA, 1'b0);
    wait_idx(8'd10);
    l_in = B; r_in = C; kl_in = KB; kr_in = KB; mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    check("busy_ignore", {l_out, r_out}, expa);
    drain();

    // synchronous reset mid-run
    start_block(B, D, KB, KA, 1'b1);
    wait_idx(8'd20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_flags", {busy, out_valid, rnd_en, in_ready}, 4'b0001);
    check("mid_rst_idx", rnd_idx, 0);
    check("mid_rst_data", {l_out, rnd_l}, 0);

`ifdef SEA_ABORT_EN
    start_block(A, C, KA, KB, 1'b0);
    wait_idx(8'd30);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {in_ready, busy, rnd_en, out_valid}, 4'b1000);
    check("abort_clear", {rnd_l, r_out}, 0);
    sw = 0;
    repeat (NR + 5) begin @(negedge clk); if (out_valid) sw++; end
    check("abort_no_valid", sw, 0);
`endif

    // recovery after reset
    start_block(C, B, KB, KB, 1'b0);
    wait_done();
    check("post_rst_result", {l_out, r_out}, sea_model(C, B, KB, KB, 1'b0, 1'b0));
    drain();

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
